key_bit_editor: RTL and testbench

Parametrised key-driven bit editor: four debounced push-button levels move a cursor over a WIDTH-bit register, toggle the bit under the cursor, or clear everything. It is the successor of the two-key 8-bit editor. It adds configurable width, bidirectional cursor movement, a clear key, explicit key priority, auto-repeat on held cursor keys, and a change strobe. It sits behind the per-key debouncers and drives the board LEDs (data and cursor) and any logic consuming the edited word.

---
 rtl/key_bit_editor_if.sv | 14 +
 rtl/key_bit_editor.sv | 95 +++++++++
 tb/tb_key_bit_editor.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/key_bit_editor_if.sv
// key_bit_editor_if: debounced key levels in, edited word, cursor and change strobe out
interface key_bit_editor_if #(parameter int WIDTH = 8);
  localparam int CURW = $clog2(WIDTH);
  logic key_next;
  logic key_prev;
  logic key_tog;
  logic key_clr;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] sout;
  logic [CURW-1:0] cur;
  logic chg;
  modport master(output key_next, key_prev, key_tog, key_clr, input dout, sout, cur, chg);
  modport slave(input key_next, key_prev, key_tog, key_clr, output dout, sout, cur, chg);
endinterface

// File: rtl/key_bit_editor.sv
// key_bit_editor: key-driven cursor/toggle/clear editor with auto-repeat on cursor keys
module key_bit_editor #(
  parameter int WIDTH      = 8,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  key_bit_editor_if.slave  bus
);
  localparam int CURW = $clog2(WIDTH);
  localparam int CNTW = $clog2(REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER);
  typedef enum logic [1:0] {INIT, READY, HOLD, RPT} state_t;
  typedef enum logic [1:0] {K_NEXT, K_PREV, K_TOG, K_CLR} key_t;
  state_t state, state_n;
  key_t key_q, key_n, act_k, win;
  logic [CNTW-1:0] cnt, cnt_n;
  logic act, lat, any_key, is_mv;
  logic [WIDTH-1:0] dout_q;
  logic [CURW-1:0] cur_q;
  logic chg_q;
  assign any_key = bus.key_next | bus.key_prev | bus.key_tog | bus.key_clr;
  assign win = bus.key_clr ? K_CLR : bus.key_tog ? K_TOG : bus.key_next ? K_NEXT : K_PREV;
  assign lat = key_q == K_NEXT ? bus.key_next : key_q == K_PREV ? bus.key_prev :
               key_q == K_TOG ? bus.key_tog : bus.key_clr;
  assign is_mv = key_q == K_NEXT || key_q == K_PREV;
  // FSM state, latched key and repeat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      key_q <= K_NEXT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      key_q <= key_n;
      cnt   <= cnt_n;
    end
  end
  // next state and action select; release of the latched key beats a coincident repeat
  always_comb begin
    state_n = state;
    key_n   = key_q;
    cnt_n   = cnt;
    act     = 1'b0;
    act_k   = key_q;
    case (state)
      INIT: state_n = READY;
      READY: begin
        if (any_key) begin
          act     = 1'b1;
          act_k   = win;
          key_n   = win;
          cnt_n   = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!lat) state_n = READY;
        else if (is_mv && cnt == CNTW'(REPEAT_DLY - 1)) begin
          act     = 1'b1;
          cnt_n   = '0;
          state_n = RPT;
        end else cnt_n = (&cnt) ? cnt : cnt + 1'b1;
      end
      RPT: begin
        if (!lat) state_n = READY;
        else if (cnt == CNTW'(REPEAT_PER - 1)) begin
          act   = 1'b1;
          cnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      end
      default: state_n = INIT;
    endcase
  end
  // data word, cursor and change strobe, updated on every executed action
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      cur_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      chg_q <= act;
      if (act) begin
        cur_q  <= act_k == K_CLR ? '0 :
                  act_k == K_NEXT ? (cur_q == CURW'(WIDTH - 1) ? '0 : cur_q + 1'b1) :
                  act_k == K_PREV ? (cur_q == '0 ? CURW'(WIDTH - 1) : cur_q - 1'b1) : cur_q;
        dout_q <= act_k == K_CLR ? '0 : act_k == K_TOG ? dout_q ^ (WIDTH'(1) << cur_q) : dout_q;
      end
    end
  end
  assign bus.dout = dout_q;
  assign bus.cur  = cur_q;
  assign bus.chg  = chg_q;
  assign bus.sout = WIDTH'(1) << cur_q;
endmodule

// File: tb/tb_key_bit_editor.sv
// tb_key_bit_editor: randomized and directed checks against a press-timeline model
module tb_key_bit_editor;
  localparam int W = 8;
  localparam int D = 4;
  localparam int P = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  key_bit_editor_if #(.WIDTH(W)) bus();
  key_bit_editor #(.WIDTH(W), .REPEAT_DLY(D), .REPEAT_PER(P)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  logic [W-1:0] m_dout;
  logic [2:0] m_cur;
  logic m_chg, m_init;
  int m_held, m_t;
  logic [19:0] got, exp_v;
  assign got = {bus.dout, bus.sout, bus.cur, bus.chg};
  assign exp_v = {m_dout, (8'(1) << m_cur), m_cur, m_chg};
  // model: actions at the press edge, then DLY edges later, then every PER edges while held
  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0] d;
    logic [3:0] kv;
    int c, h, t, a;
    if (!rst_n) begin
      m_dout <= '0; m_cur <= '0; m_chg <= 1'b0; m_init <= 1'b1; m_held <= -1; m_t <= 0;
    end else begin
      d = m_dout; c = int'(m_cur); h = m_held; t = m_t; a = -1;
      kv = {bus.key_clr, bus.key_tog, bus.key_prev, bus.key_next};
      if (m_init) m_init <= 1'b0;
      else if (h < 0) begin
        if (kv != 0) begin
          a = kv[3] ? 3 : kv[2] ? 2 : kv[0] ? 0 : 1;
          h = a; t = 0;
        end
      end else if (!kv[h]) h = -1;
      else begin
        t++;
        if (h < 2 && t >= D && (t - D) % P == 0) a = h;
      end
      if (a == 0) c = (c == W - 1) ? 0 : c + 1;
      else if (a == 1) c = (c == 0) ? W - 1 : c - 1;
      else if (a == 2) d[c] = ~d[c];
      else if (a == 3) begin d = '0; c = 0; end
      m_dout <= d; m_cur <= 3'(c); m_chg <= (a >= 0); m_held <= h; m_t <= t;
    end
  end
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_keys(input logic [3:0] k);
    {bus.key_clr, bus.key_tog, bus.key_prev, bus.key_next} = k;
  endtask
  task automatic press(input int k);
    set_keys(4'(1 << k));
    cyc();
    set_keys(4'b0);
    cyc();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    set_keys(4'b0);
    repeat (3) cyc();
    checks++; if (got !== {8'h00, 8'h01, 3'd0, 1'b0}) $display("FAIL reset_vals: got %h expected %h", got, {8'h00, 8'h01, 3'd0, 1'b0}); else passes++;
    rst_n = 1'b1;
    set_keys(4'b0100);
    cyc();
    checks++; if (got !== {8'h00, 8'h01, 3'd0, 1'b0}) $display("FAIL init_ignore: got %h expected %h", got, {8'h00, 8'h01, 3'd0, 1'b0}); else passes++;
    set_keys(4'b0);
    cyc();
    checks++; if (got !== exp_v) $display("FAIL reset_model: got %h expected %h", got, exp_v); else passes++;
  endtask
  task automatic test_toggle();
    int n = 0;
    set_keys(4'b0100);
    for (int i = 0; i < 20; i++) begin
      cyc();
      n += int'(bus.chg);
      checks++; if (got !== exp_v) $display("FAIL toggle_model: cycle %0d got %h expected %h", i, got, exp_v); else passes++;
      if (i == 0) begin
        checks++; if (bus.dout !== 8'h01) $display("FAIL toggle_first: dout %h expected 01", bus.dout); else passes++;
      end
    end
    set_keys(4'b0);
    cyc();
    checks++; if (n != 1 || bus.dout !== 8'h01) $display("FAIL toggle_once: chg pulses %0d dout %h expected 1 and 01", n, bus.dout); else passes++;
  endtask
  task automatic test_wrap();
    int n = 0;
    set_keys(4'b0010);
    cyc(); n += int'(bus.chg);
    checks++; if (bus.cur !== 3'd7 || bus.sout !== 8'h80) $display("FAIL wrap_prev: cur %0d sout %h expected 7 80", bus.cur, bus.sout); else passes++;
    set_keys(4'b0);
    cyc(); n += int'(bus.chg);
    set_keys(4'b0001);
    cyc(); n += int'(bus.chg);
    checks++; if (bus.cur !== 3'd0 || bus.sout !== 8'h01) $display("FAIL wrap_next: cur %0d sout %h expected 0 01", bus.cur, bus.sout); else passes++;
    set_keys(4'b0);
    cyc(); n += int'(bus.chg);
    checks++; if (n != 2) $display("FAIL wrap_chg: pulses %0d expected 2", n); else passes++;
  endtask
  task automatic test_repeat();
    int exp_cur[9] = '{1, 1, 1, 1, 2, 2, 3, 3, 4};
    int n = 0;
    set_keys(4'b0001);
    for (int k = 0; k < 9; k++) begin
      cyc();
      n += int'(bus.chg);
      checks++; if (int'(bus.cur) != exp_cur[k] || got !== exp_v) $display("FAIL repeat_step: edge N+%0d cur %0d expected %0d (got %h model %h)", k, bus.cur, exp_cur[k], got, exp_v); else passes++;
    end
    set_keys(4'b0);
    repeat (3) begin cyc(); n += int'(bus.chg); end
    checks++; if (bus.cur !== 3'd4 || n != 4) $display("FAIL repeat_total: cur %0d chg %0d expected 4 4", bus.cur, n); else passes++;
  endtask
  task automatic test_priority();
    int seq[11] = '{3, 2, 0, 0, 2, 0, 0, 0, 2, 1, 1};
    foreach (seq[i]) press(seq[i]);
    checks++; if (bus.dout !== 8'h25 || bus.cur !== 3'd3) $display("FAIL prio_setup: dout %h cur %0d expected 25 3", bus.dout, bus.cur); else passes++;
    set_keys(4'b1001);
    cyc();
    checks++; if (got !== {8'h00, 8'h01, 3'd0, 1'b1}) $display("FAIL prio_clr: got %h expected %h", got, {8'h00, 8'h01, 3'd0, 1'b1}); else passes++;
    repeat (3) begin
      cyc();
      checks++; if (got !== exp_v) $display("FAIL prio_hold: got %h expected %h", got, exp_v); else passes++;
    end
    set_keys(4'b0001);
    cyc();
    checks++; if (bus.cur !== 3'd0 || bus.chg !== 1'b0) $display("FAIL prio_release: cur %0d chg %b expected 0 0", bus.cur, bus.chg); else passes++;
    cyc();
    checks++; if (bus.cur !== 3'd1 || bus.chg !== 1'b1) $display("FAIL prio_next: cur %0d chg %b expected 1 1", bus.cur, bus.chg); else passes++;
    set_keys(4'b0);
    cyc();
  endtask
  task automatic test_reset_mid();
    bit found = 0;
    press(3);
    set_keys(4'b0001);
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      checks++; if (got !== exp_v) $display("FAIL midrst_run: got %h expected %h", got, exp_v); else passes++;
      found = (bus.cur == 3'd5);
    end
    checks++; if (!found) $display("FAIL midrst_reach: cur %0d expected 5 within 30 cycles", bus.cur); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (got !== {8'h00, 8'h01, 3'd0, 1'b0}) $display("FAIL midrst_async: got %h expected %h", got, {8'h00, 8'h01, 3'd0, 1'b0}); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++; if (bus.cur !== 3'd0 || bus.chg !== 1'b0) $display("FAIL midrst_init: cur %0d chg %b expected 0 0", bus.cur, bus.chg); else passes++;
    cyc();
    checks++; if (bus.cur !== 3'd1 || bus.chg !== 1'b1) $display("FAIL midrst_new: cur %0d chg %b expected 1 1", bus.cur, bus.chg); else passes++;
    cyc();
    checks++; if (bus.cur !== 3'd1 || bus.chg !== 1'b0) $display("FAIL midrst_hold: cur %0d chg %b expected 1 0", bus.cur, bus.chg); else passes++;
    set_keys(4'b0);
    cyc();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) set_keys(4'($urandom));
      cyc();
      checks++; if (got !== exp_v) $display("FAIL random: cycle %0d got %h expected %h", i, got, exp_v); else passes++;
    end
    set_keys(4'b0);
    cyc();
  endtask
  initial begin
    set_keys(4'b0);
    test_reset();
    test_toggle();
    test_wrap();
    test_repeat();
    test_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
